// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the memory responder.
package mem_responder_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_STARVE_MAX = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } stateT;

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port RAM, synchronous read and write, no reset on the array or output.
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // One access per cycle: write the array, or register the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Two-port (fetch/data) responder in front of one single-port RAM.
// After reset the RAM is zeroed by a sweep; then data has priority,
// with the fetch port forced through after STARVE_MAX data grants.
//
//   state | meaning
//   CLEAR | zeroing word clrCnt each cycle, ports held off, busy=1
//   RUN   | arbitrating fetch and data requests, one access per cycle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [15:0]       i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    stateT               state, stateNext;
    logic [ADDR_W-1:0]   clrCnt;
    logic [STARVE_W-1:0] starveCnt;
    logic                forceI;

    logic                ramEn, ramWe;
    logic [ADDR_W-1:0]   ramAddr;
    logic [DATA_W-1:0]   ramWdata, ramRdata;
    logic [DATA_W-1:0]   iRdataHold, dRdataHold;

    // Upper address bits are deliberately ignored; words alias modulo depth.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{i_addr[15:ADDR_W], d_addr[15:ADDR_W]};

    // Next state, grants and RAM port steering.
    always_comb begin
        stateNext = state;
        busy      = 1'b1;
        forceI    = 1'b0;
        d_ready   = 1'b0;
        i_ready   = 1'b0;
        ramEn     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = clrCnt;
        ramWdata  = '0;
        case (state)
            CLEAR: begin
                ramEn = 1'b1;
                ramWe = 1'b1;
                if (clrCnt == '1) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                busy    = 1'b0;
                forceI  = i_req && (starveCnt == STARVE_W'(STARVE_MAX));
                d_ready = d_req && !forceI;
                i_ready = i_req && !d_ready;
                if (d_ready) begin
                    ramEn    = 1'b1;
                    ramWe    = d_we;
                    ramAddr  = d_addr[ADDR_W-1:0];
                    ramWdata = d_wdata;
                end else if (i_ready) begin
                    ramEn   = 1'b1;
                    ramAddr = i_addr[ADDR_W-1:0];
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    // State, sweep address and fetch-starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clrCnt    <= '0;
            starveCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == CLEAR) begin
                clrCnt <= clrCnt + ADDR_W'(1);
            end
            if (state == RUN) begin
                if (!i_req || i_ready) begin
                    starveCnt <= '0;
                end else if (d_ready) begin
                    starveCnt <= starveCnt + STARVE_W'(1);
                end
            end
        end
    end

    // Read-valid pulses and per-port capture of the last returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            iRdataHold <= '0;
            dRdataHold <= '0;
        end else begin
            i_rvalid <= i_ready;
            d_rvalid <= d_ready && !d_we;
            if (i_rvalid) begin
                iRdataHold <= ramRdata;
            end
            if (d_rvalid) begin
                dRdataHold <= ramRdata;
            end
        end
    end

    // RAM output is live only in the rvalid cycle; otherwise show the held word.
    assign i_rdata = i_rvalid ? ramRdata : iRdataHold;
    assign d_rdata = d_rvalid ? ramRdata : dRdataHold;

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) uRam (
        .clk   (clk),
        .en    (ramEn),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

endmodule
